// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: PC-1 on start, 16-round C/D rotation, one PC-2 subkey per round.
// Latency: start sampled at edge N -> first subkey valid after N; done pulses after the 16th accept.
// Backpressure: subkey_valid/subkey_ready handshake; C/D and round_idx hold while ready is low.
//
// Ports: Clk/Reset (async, active-high); start/decrypt/key_in capture a key in IDLE;
// subkey/subkey_valid/subkey_ready/round_idx carry round keys; busy/done/parity_err report status.
// Optional: define DES_KEY_PARITY_CHECK_EN to reject keys with an even-parity byte (parity_err pulse).

// Fixed DES PC-2 selection: 56-bit C/D (bit 55 = DES bit 1) -> 48-bit subkey (bit 47 = DES bit 1).
module des_pc2 (
    input  logic [55:0] cd,
    output logic [47:0] subkey
);
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey[47-i] = cd[56-PC2_TBL[i]];
    end
endmodule

module des_key_scheduler #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic        decrypt_q, decrypt_d;
    logic [55:0] pc1_key;
    logic        key_ok;

    // PC-1 drops the eight parity bits (DES bits 8,16,..,64 = key_in[0],[8],..,[56]).
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_key[55-i] = key_in[64-PC1_TBL[i]];
    end

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
    function automatic logic single_shift(input logic [4:0] rnd);
        return (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
    endfunction

    // Each 28-bit half rotates independently.
    function automatic logic [55:0] rotl_cd(input logic [55:0] v, input logic one);
        logic [27:0] c, d;
        c = v[55:28];
        d = v[27:0];
        if (one) return {c[26:0], c[27], d[26:0], d[27]};
        return {c[25:0], c[27:26], d[25:0], d[27:26]};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] v, input logic one);
        logic [27:0] c, d;
        c = v[55:28];
        d = v[27:0];
        if (one) return {c[0], c[27:1], d[0], d[27:1]};
        return {c[1:0], c[27:2], d[1:0], d[27:2]};
    endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
    logic       parity_err_q, parity_err_d;
    logic [7:0] byte_odd;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^key_in[8*b +: 8];
    end
    assign key_ok     = &byte_odd;
    assign parity_err = parity_err_q;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                  key_in[24], key_in[16], key_in[8], key_in[0]};
    assign key_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        round_idx_d = round_idx_q;
        decrypt_d   = decrypt_q;
`ifdef DES_KEY_PARITY_CHECK_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (key_ok) begin
                        state_d   = ROUND;
                        decrypt_d = decrypt;
                        if (decrypt) begin
                            // Full schedule rotates each half by 28, so PC-1 output is C16/D16.
                            cd_d        = pc1_key;
                            round_idx_d = LAST_IDX;
                        end else begin
                            cd_d        = rotl_cd(pc1_key, 1'b1);
                            round_idx_d = 4'd0;
                        end
                    end else begin
`ifdef DES_KEY_PARITY_CHECK_EN
                        parity_err_d = 1'b1;
`endif
                    end
                end
            end
            ROUND: begin
                if (subkey_ready) begin
                    if (decrypt_q ? (round_idx_q == 4'd0) : (round_idx_q == LAST_IDX)) begin
                        state_d = DONE;
                    end else if (decrypt_q) begin
                        // Undo the rotation that produced the current round's C/D.
                        cd_d        = rotr_cd(cd_q, single_shift({1'b0, round_idx_q} + 5'd1));
                        round_idx_d = round_idx_q - 4'd1;
                    end else begin
                        cd_d        = rotl_cd(cd_q, single_shift({1'b0, round_idx_q} + 5'd2));
                        round_idx_d = round_idx_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cd_q        <= '0;
            round_idx_q <= '0;
            decrypt_q   <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            round_idx_q <= round_idx_d;
            decrypt_q   <= decrypt_d;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    des_pc2 u_pc2 (
        .cd     (cd_q),
        .subkey (subkey)
    );

    assign subkey_valid = (state_q == ROUND);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign round_idx    = round_idx_q;
endmodule

// File: doc/des_key_scheduler.md
Name: des_key_scheduler

Overview:
Sequences DES subkey generation for the round datapath. Accepts a 64-bit key on start and applies PC-1. It then walks the 16-round C/D rotation schedule and presents one 48-bit PC-2 subkey per round over a valid/ready handshake. Subkeys are issued in encrypt order (K1..K16) or decrypt order (K16..K1); PC-2 is provided by the existing PC-2 permutation block instantiated inside.

Parameters:
NUM_ROUNDS, 16, number of subkeys issued per key; fixed by DES and not to be overridden.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
start  in  1  begin schedule; sampled only in IDLE
decrypt  in  1  sampled with start; 1 = issue K16..K1
key_in  in  64  DES key, bit 63 = DES bit 1 (parity bits ignored by PC-1)
subkey  out  48  PC-2 of current C/D register, bit 47 = DES bit 1
subkey_valid  out  1  subkey holds a valid round key
subkey_ready  in  1  consumer accepts subkey this cycle
round_idx  out  4  DES round of current subkey, 0 = K1 .. 15 = K16
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last subkey is accepted
parity_err  out  1  key parity fault, see Optional Feature

Behaviour:
- Reset (async): state = IDLE; CD = 0; round_idx = 0; subkey_valid = 0, busy = 0, done = 0, parity_err = 0; stored decrypt flag = 0. subkey = PC-2(0) = 0.
- CD register: 56 bits, C = CD[55:28], D = CD[27:0]. Rotations act independently on each 28-bit half.
- Shift schedule by round r (1..16): 1 for r in {1,2,9,16}, else 2. Total rotation over 16 rounds = 28.
- States:
  - IDLE: on start=1, capture decrypt and go to ROUND.
    - Encrypt: CD <= rotl1(PC1(key_in)), round_idx <= 0.
    - Decrypt: CD <= PC1(key_in), which equals C16D16; round_idx <= 15.
  - ROUND: subkey_valid = 1, busy = 1. Hold CD while subkey_ready = 0. On valid && ready:
    - If last round (round_idx = 15 encrypt, 0 decrypt): go to DONE.
    - Encrypt otherwise: round_idx++; CD <= rotl(CD, shift(round_idx+2)).
    - Decrypt otherwise: CD <= rotr(CD, shift(round_idx+1)); round_idx--.
  - DONE: done = 1 and busy = 1 for one cycle; subkey_valid = 0; go to IDLE. CD and round_idx hold their last values.
- Latency: start accepted at edge N gives subkey_valid at N+1. With ready tied high, 16 subkeys appear on consecutive cycles and done pulses at N+17.
- subkey is combinational PC-2 of CD, so it is stable whenever valid is high and ready is low.
- start in ROUND or DONE is ignored. key_in and decrypt are don't-care after capture.
- Reset asserted mid-schedule aborts immediately to the reset values. No partial subkey is issued after reset deasserts.
- subkey_ready while subkey_valid = 0 has no effect.

Optional Feature:
Macro DES_KEY_PARITY_CHECK_EN.
- Defined: on start in IDLE, check every key_in byte for odd parity.
  - Any byte has even parity: stay in IDLE, assert parity_err for exactly one cycle, no subkeys issued.
  - Otherwise: parity_err = 0 and normal operation.
- Undefined: parity_err is tied to 0 and parity bits are ignored.

Test Plan:
- Encrypt, key_in = 0x133457799BBCDFF1, ready tied high -> subkey = 0x1B02EFFC7072 at round_idx 0, 0x79AED9DBC9E5 at round_idx 1, 0xCB3D8B0E17F5 at round_idx 15; done at start+17.
- Decrypt, same key -> first subkey 0xCB3D8B0E17F5 with round_idx 15; last subkey 0x1B02EFFC7072 with round_idx 0; full sequence equals the encrypt sequence reversed.
- Backpressure: ready toggles with random stalls, including a 5-cycle stall on round 8 -> subkey and round_idx stay stable while stalled; 16 accepts total; values match the encrypt golden list.
- Start pulsed during ROUND with a different key -> ignored; sequence still matches the first key.
- Reset asserted at round_idx 6 -> next cycle busy = 0, subkey_valid = 0, round_idx = 0; a new start issues a fresh K1.
- With DES_KEY_PARITY_CHECK_EN: key_in = 0x123457799BBCDFF1 -> parity_err pulses 1 cycle, busy stays 0. Key 0x133457799BBCDFF1 -> parity_err stays 0 and the schedule runs.
